// File: rtl/ram_check_pkg.sv
// ram_check_pkg: shared FSM states, pattern codes and expected-bit helper for the RAM readback checker.
package ram_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_ZERO = 2'd0,
        PAT_ONE  = 2'd1,
        PAT_ALT  = 2'd2,
        PAT_NALT = 2'd3
    } pat_t;

    function automatic logic exp_bit(pat_t p, logic a0);
        return p == PAT_ZERO ? 1'b0 : p == PAT_ONE ? 1'b1 : p == PAT_ALT ? a0 : ~a0;
    endfunction

endpackage

// File: rtl/ram_readback_checker_if.sv
// ram_readback_checker_if: read-beat stream in, check status out.
interface ram_readback_checker_if #(
    parameter int A_WIDTH = 8,
    parameter int ERR_W   = 16
);
    logic               start_i;
    logic [1:0]         pattern_i;
    logic               valid_i;
    logic [A_WIDTH-1:0] addr_i;
    logic               q_i;
    logic               busy_o;
    logic               done_o;
    logic               pass_o;
    logic [ERR_W-1:0]   err_count_o;
    logic [A_WIDTH-1:0] first_err_addr_o;
    logic               first_err_valid_o;

    modport slave (
        input  start_i, pattern_i, valid_i, addr_i, q_i,
        output busy_o, done_o, pass_o, err_count_o, first_err_addr_o, first_err_valid_o
    );

    modport master (
        output start_i, pattern_i, valid_i, addr_i, q_i,
        input  busy_o, done_o, pass_o, err_count_o, first_err_addr_o, first_err_valid_o
    );
endinterface

// File: rtl/pipe_delay.sv
// pipe_delay: W-bit delay line of depth D with synchronous flush; depth 0 is a plain wire.
module pipe_delay #(
    parameter int W = 1,
    parameter int D = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (D == 0) begin : g_wire
        logic unused;
        assign unused = &{1'b0, clk_i, rst_ni, clr};
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] sr [D];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) sr <= '{default: '0};
            else if (clr) sr <= '{default: '0};
            else begin
                sr[0] <= d;
                for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[D-1];
    end
endmodule

// File: rtl/ram_readback_checker.sv
// ram_readback_checker: compares 2**A_WIDTH RAM read beats against a fixed pattern and reports errors.
module ram_readback_checker
    import ram_check_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int LATENCY = 0,
    parameter int ERR_W   = 16
) (
    input logic clk_i,
    input logic rst_ni,
    ram_readback_checker_if.slave bus
);
    state_t             state, state_nx;
    pat_t               pat;
    logic               dvalid;
    logic [A_WIDTH-1:0] daddr;
    logic [A_WIDTH:0]   cnt;
    logic [ERR_W-1:0]   err;
    logic [A_WIDTH-1:0] fe_addr;
    logic               fe_valid;
    logic               enter, beat, miss, last;

    assign enter = bus.start_i && (state == ST_IDLE || state == ST_DONE);
    assign beat  = dvalid && state == ST_CHECK;
    assign miss  = beat && (bus.q_i != exp_bit(pat, daddr[0]));
    assign last  = beat && cnt == {1'b0, {A_WIDTH{1'b1}}};

    // Flushing on CHECK entry also drops the beat presented alongside start.
    pipe_delay #(.W(A_WIDTH + 1), .D(LATENCY)) u_dly (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr   (enter),
        .d     ({bus.valid_i, bus.addr_i}),
        .q     ({dvalid, daddr})
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == ST_IDLE  ? (bus.start_i ? ST_CHECK : ST_IDLE) :
                   state == ST_CHECK ? (last ? ST_DONE : ST_CHECK) :
                   state == ST_DONE  ? (bus.start_i ? ST_CHECK : ST_DONE) : ST_IDLE;
    end

    always_comb begin
        bus.busy_o            = state == ST_CHECK;
        bus.done_o            = state == ST_DONE;
        bus.pass_o            = state == ST_DONE && err == '0;
        bus.err_count_o       = err;
        bus.first_err_addr_o  = fe_addr;
        bus.first_err_valid_o = fe_valid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= '0;
            err      <= '0;
            pat      <= PAT_ZERO;
            fe_addr  <= '0;
            fe_valid <= 1'b0;
        end else if (enter) begin
            cnt      <= '0;
            err      <= '0;
            pat      <= pat_t'(bus.pattern_i);
            fe_valid <= 1'b0;
        end else if (beat) begin
            cnt <= cnt + 1'b1;
            if (miss && err != '1) err <= err + 1'b1;
            if (miss && !fe_valid) begin
                fe_valid <= 1'b1;
                fe_addr  <= daddr;
            end
        end
    end
endmodule

// File: tb/tb_ram_readback_checker.sv
// tb_ram_readback_checker: randomized and directed checks of three checker configurations against a pass-level model.
module tb_ram_readback_checker;
    localparam int N = 3;
    localparam int LAT [N] = '{0, 2, 0};
    localparam int EW  [N] = '{16, 16, 4};

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [7:0] addr = 8'd0;
    logic       qv [N];
    logic       o_busy [N], o_done [N], o_pass [N], o_fev [N];
    logic [7:0]  o_fea [N];
    logic [15:0] o_err [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        ram_readback_checker_if #(.A_WIDTH(8), .ERR_W(EW[k])) bi ();
        assign bi.start_i   = start;
        assign bi.pattern_i = pattern;
        assign bi.valid_i   = valid;
        assign bi.addr_i    = addr;
        assign bi.q_i       = qv[k];
        assign o_busy[k] = bi.busy_o;
        assign o_done[k] = bi.done_o;
        assign o_pass[k] = bi.pass_o;
        assign o_fev[k]  = bi.first_err_valid_o;
        assign o_fea[k]  = bi.first_err_addr_o;
        assign o_err[k]  = 16'(bi.err_count_o);
        ram_readback_checker #(.A_WIDTH(8), .LATENCY(LAT[k]), .ERR_W(EW[k])) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bi)
        );
    end

    // Pass-level model: what each checker must report, from the beats it has seen
    bit         m_busy [N], m_done [N], m_fev [N];
    int         m_cnt [N], m_err [N], m_fea [N];
    logic [1:0] m_pat [N];
    bit         hv [N][4];
    int         ha [N][4];
    bit         dv [N];
    int         da [N];
    int         mode = 0;
    logic [1:0] ram_pat = 2'd0;
    int         errors = 0, checks = 0;

    function automatic bit pat_bit(logic [1:0] p, int a);
        return p == 2'd0 ? 1'b0 : p == 2'd1 ? 1'b1 : p == 2'd2 ? a[0] : !a[0];
    endfunction

    function automatic logic ram_q(int a);
        case (mode)
            0: return pat_bit(ram_pat, a);
            1: return (a == 16 || a == 32) ? 1'b1 : pat_bit(ram_pat, a);
            2: return pat_bit(ram_pat, a - 1);
            3: return 1'b1;
            default: return pat_bit(ram_pat, a) ^ ($urandom_range(0, 15) == 0);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic prep();
        for (int k = 0; k < N; k++) begin
            if (LAT[k] == 0) begin
                dv[k] = valid;
                da[k] = int'(addr);
            end else begin
                dv[k] = hv[k][LAT[k]-1];
                da[k] = ha[k][LAT[k]-1];
            end
            qv[k] = dv[k] ? ram_q(da[k]) : 1'($urandom);
        end
    endtask

    task automatic model_edge();
        bit enter;
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_done[k] = 0; m_fev[k] = 0;
                m_cnt[k] = 0; m_err[k] = 0; m_fea[k] = 0; m_pat[k] = 0;
                for (int i = 0; i < 4; i++) begin hv[k][i] = 0; ha[k][i] = 0; end
            end else begin
                enter = !m_busy[k] && start;
                if (m_busy[k] && dv[k]) begin
                    m_cnt[k]++;
                    if (qv[k] != pat_bit(m_pat[k], da[k])) begin
                        if (m_err[k] < (1 << EW[k]) - 1) m_err[k]++;
                        if (!m_fev[k]) begin m_fev[k] = 1; m_fea[k] = da[k]; end
                    end
                    if (m_cnt[k] == 256) begin m_busy[k] = 0; m_done[k] = 1; end
                end
                if (enter) begin
                    m_busy[k] = 1; m_done[k] = 0; m_fev[k] = 0;
                    m_cnt[k] = 0; m_err[k] = 0; m_pat[k] = pattern;
                    for (int i = 0; i < 4; i++) begin hv[k][i] = 0; ha[k][i] = 0; end
                end else begin
                    for (int i = 3; i > 0; i--) begin hv[k][i] = hv[k][i-1]; ha[k][i] = ha[k][i-1]; end
                    hv[k][0] = valid;
                    ha[k][0] = int'(addr);
                end
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < N; k++) begin
            check($sformatf("busy%0d", k), o_busy[k], m_busy[k]);
            check($sformatf("done%0d", k), o_done[k], m_done[k]);
            check($sformatf("pass%0d", k), o_pass[k], m_done[k] && m_err[k] == 0);
            check($sformatf("err%0d", k), o_err[k], m_err[k]);
            check($sformatf("fev%0d", k), o_fev[k], m_fev[k]);
            check($sformatf("fea%0d", k), o_fea[k], m_fea[k]);
        end
    endtask

    task automatic tick();
        prep();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic start_pass(input logic [1:0] p, input int md);
        mode = md;
        ram_pat = p;
        start = 1'b1;
        pattern = p;
        tick();
        start = 1'b0;
        pattern = 2'($urandom);
    endtask

    // gm: 0 back-to-back, 1 every other cycle, 2 random gaps/addresses/stray starts
    task automatic beats(input int lo, input int n, input int gm);
        for (int i = lo; i < lo + n; i++) begin
            valid = 1'b1;
            addr = gm == 2 ? 8'($urandom) : 8'(i);
            start = gm == 2 && $urandom_range(0, 63) == 0;
            tick();
            start = 1'b0;
            if (gm == 1 || (gm == 2 && $urandom_range(0, 2) == 0)) begin
                valid = 1'b0;
                addr = 8'($urandom);
                tick();
            end
        end
        valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        for (int k = 0; k < N; k++) qv[k] = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", o_busy[0], 0);
        check("rst_done", o_done[0], 0);
        check("rst_err", o_err[0], 0);
        check("rst_fev", o_fev[0], 0);
        rst_n = 1'b1;
        tick();

        start_pass(2'd2, 0);
        beats(0, 255, 0);
        check("s1_done_early", o_done[0], 0);
        beats(255, 1, 0);
        check("s1_done_256", o_done[0], 1);
        check("s1_lat2_pending", o_done[1], 0);
        drain();
        check("s1_pass", o_pass[0], 1);
        check("s1_err", o_err[0], 0);
        check("s1_lat2_done", o_done[1], 1);

        start_pass(2'd2, 1);
        beats(0, 256, 0);
        drain();
        check("s2_err", o_err[0], 2);
        check("s2_fea", o_fea[0], 8'h10);
        check("s2_fev", o_fev[0], 1);
        check("s2_pass", o_pass[0], 0);

        start_pass(2'd3, 0);
        beats(0, 256, 1);
        drain();
        check("s3_lat2_pass", o_pass[1], 1);

        start_pass(2'd3, 2);
        beats(0, 256, 1);
        drain();
        check("s4_lat2_err", o_err[1], 256);
        check("s4_sat_err", o_err[2], 15);

        start_pass(2'd0, 3);
        beats(0, 256, 0);
        drain();
        check("s5_sat_err", o_err[2], 15);
        check("s5_sat_pass", o_pass[2], 0);
        check("s5_full_err", o_err[0], 256);

        start_pass(2'd2, 0);
        beats(0, 100, 0);
        rst_n = 1'b0;
        tick();
        check("s6_rst_busy", o_busy[0], 0);
        check("s6_rst_busy_lat", o_busy[1], 0);
        rst_n = 1'b1;
        beats(0, 256, 0);
        drain();
        check("s6_no_done", o_done[0], 0);
        check("s6_no_done_lat", o_done[1], 0);

        start_pass(2'd1, 0);
        beats(0, 100, 0);
        start = 1'b1;
        pattern = 2'd0;
        beats(100, 1, 0);
        start = 1'b0;
        beats(101, 155, 0);
        drain();
        check("s7_done", o_done[0], 1);
        check("s7_pass", o_pass[0], 1);
        start_pass(2'd0, 0);
        check("s7_restart_busy", o_busy[0], 1);
        check("s7_restart_done", o_done[0], 0);
        check("s7_restart_err", o_err[0], 0);
        beats(0, 256, 0);
        drain();
        check("s7_second_pass", o_pass[0], 1);

        repeat (6) begin
            start_pass(2'($urandom), 4);
            beats(0, 256, 2);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
